// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared step encoding, opcode and ALU-select constants for the control sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

  // One-hot step encoding: every state owns exactly one flop bit.
  typedef enum logic [8:0] {
    IDLE  = 9'b000000001,
    T0    = 9'b000000010,
    T1    = 9'b000000100,
    T2    = 9'b000001000,
    T3    = 9'b000010000,
    T4    = 9'b000100000,
    T5    = 9'b001000000,
    HALT  = 9'b010000000,
    FAULT = 9'b100000000
  } step_t;

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_NEG  = 5'h08;
  localparam logic [4:0] OP_NOT  = 5'h09;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [11:0] ALU_ADD = 12'h001;
  localparam logic [11:0] ALU_SUB = 12'h002;
  localparam logic [11:0] ALU_AND = 12'h004;
  localparam logic [11:0] ALU_OR  = 12'h008;
  localparam logic [11:0] ALU_NEG = 12'h400;
  localparam logic [11:0] ALU_NOT = 12'h800;

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_binary(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Zero for anything that is not an ALU opcode.
  function automatic logic [11:0] alu_sel(input logic [4:0] op);
    logic [11:0] sel;
    sel = 12'h000;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_NEG:  sel = ALU_NEG;
      OP_NOT:  sel = ALU_NOT;
      default: sel = 12'h000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Purpose: 4-bit register field to 16-bit one-hot select, forced to zero when disabled.
// Latency: combinational.
// Backpressure: none.
// Ports: field (register number), en (select enable), onehot (decoded select).
module reg_field_decoder (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot[field] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Purpose: hardwired fetch/execute sequencer driving all datapath strobes for reg-reg ALU ops.
// Latency: binary op 6 cycles, unary op 5 cycles; T1 extends while memory is not ready.
// Backpressure: holds in T1 on mem_rdy=0, FAULT after MEM_TIMEOUT T1 cycles; run gates new fetches.
// Ports: clk/clr (sync active-high), run, ir, mem_rdy in; bus/register/ALU strobes,
//        halted, fault and instr_count out.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             MDRRead,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [11:0]      ALUControl,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  step_t             state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       rout_en, rin_en;
  logic [3:0] rout_sel;
  logic       ir_unused;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign ir_unused = ^ir[14:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    count_d    = count_q;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    PCin       = 1'b0;
    MDRRead    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ALUControl = 12'h000;
    rout_en    = 1'b0;
    rout_sel   = rb;
    rin_en     = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = T0;
      end
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        wait_d  = '0;
        state_d = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        // Load PC only on the first wait cycle so a slow memory cannot double-increment it.
        PCin    = (wait_q == '0);
        MDRRead = 1'b1;
        MDRin   = 1'b1;
        if (mem_rdy) begin
          state_d = T2;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        // Strobes stay quiet for HALT/illegal opcodes; only the transition differs.
        if (is_binary(op)) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
          state_d = T4;
        end else if (is_unary(op)) begin
          rout_en    = 1'b1;
          ALUControl = alu_sel(op);
          Zin        = 1'b1;
          state_d    = T5;
        end else if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          state_d = FAULT;
        end
      end
      T4: begin
        rout_en    = 1'b1;
        rout_sel   = rc;
        ALUControl = alu_sel(op);
        Zin        = 1'b1;
        state_d    = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        rin_en  = 1'b1;
        count_d = count_q + CNT_W'(1);
        state_d = run ? T0 : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  assign instr_count = count_q;

  reg_field_decoder u_rout_dec (
    .field  (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_field_decoder u_rin_dec (
    .field  (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, mem_rdy;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRRead, MDRin, MDRout, IRin, Yin;
  logic [15:0] Rout, Rin;
  logic [11:0] ALUControl;
  logic        halted, fault;
  logic [15:0] instr_count;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in;
    logic        mdr_read, mdr_in, mdr_out, ir_in, y_in;
    logic [15:0] rout, rin;
    logic [11:0] alu;
    logic        halted, fault;
  } outs_t;

  outs_t       obs;
  outs_t       exp_q[$];
  logic [15:0] cnt_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  control_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .MDRRead(MDRRead), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Rout(Rout), .Rin(Rin), .ALUControl(ALUControl),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always_comb obs = {PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRRead, MDRin, MDRout,
                     IRin, Yin, Rout, Rin, ALUControl, halted, fault};

  function automatic outs_t ex_none();
    outs_t e = '0;
    return e;
  endfunction
  function automatic outs_t ex_t0();
    outs_t e = '0;
    e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
    return e;
  endfunction
  function automatic outs_t ex_t1(input logic first);
    outs_t e = '0;
    e.zlow_out = 1'b1; e.pc_in = first; e.mdr_read = 1'b1; e.mdr_in = 1'b1;
    return e;
  endfunction
  function automatic outs_t ex_t2();
    outs_t e = '0;
    e.mdr_out = 1'b1; e.ir_in = 1'b1;
    return e;
  endfunction
  function automatic outs_t ex_t3b(input logic [15:0] rout);
    outs_t e = '0;
    e.rout = rout; e.y_in = 1'b1;
    return e;
  endfunction
  function automatic outs_t ex_alu(input logic [15:0] rout, input logic [11:0] alu);
    outs_t e = '0;
    e.rout = rout; e.alu = alu; e.z_in = 1'b1;
    return e;
  endfunction
  function automatic outs_t ex_t5(input logic [15:0] rin);
    outs_t e = '0;
    e.zlow_out = 1'b1; e.rin = rin;
    return e;
  endfunction
  function automatic outs_t ex_halt();
    outs_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction
  function automatic outs_t ex_fault();
    outs_t e = '0;
    e.halted = 1'b1; e.fault = 1'b1;
    return e;
  endfunction

  // Queue the expectation for the cycle being launched, then check it once the DUT has clocked.
  task automatic step(input outs_t e, input logic [15:0] c, input string tag);
    outs_t       ee;
    logic [15:0] cc;
    exp_q.push_back(e);
    cnt_q.push_back(c);
    @(posedge clk);
    #1;
    ee = exp_q.pop_front();
    cc = cnt_q.pop_front();
    vectors++;
    assert (obs === ee) else begin
      miscompares++;
      $error("FAIL %s strobes observed=%h expected=%h", tag, obs, ee);
    end
    vectors++;
    assert (instr_count === cc) else begin
      miscompares++;
      $error("FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, cc);
    end
  endtask

  localparam logic [31:0] IR_NOT_5_2   = 32'h4A920000;            // NOT ra=5 rb=2
  localparam logic [31:0] IR_ADD_3_5_2 = {5'h03, 4'd3, 4'd5, 4'd2, 15'd0};
  localparam logic [31:0] IR_BAD       = {5'h1F, 27'd0};
  localparam logic [31:0] IR_HALT      = {5'h1B, 27'd0};

  initial begin
    clr = 1'b1; run = 1'b1; ir = 32'h0; mem_rdy = 1'b0;

    // Reset with run held high
    step(ex_none(), 16'd0, "rst0");
    step(ex_none(), 16'd0, "rst1");

    // NOT R5,R2 with memory immediately ready: 5 cycles
    clr = 1'b0; ir = IR_NOT_5_2; mem_rdy = 1'b1;
    step(ex_t0(), 16'd0, "not_t0");
    step(ex_t1(1'b1), 16'd0, "not_t1");
    step(ex_t2(), 16'd0, "not_t2");
    step(ex_alu(16'h0004, 12'h800), 16'd0, "not_t3");
    step(ex_t5(16'h0020), 16'd0, "not_t5");
    run = 1'b0;
    step(ex_none(), 16'd1, "not_idle");

    // ADD ra=3 rb=5 rc=2 with 4 cycles of memory wait
    run = 1'b1; ir = IR_ADD_3_5_2; mem_rdy = 1'b0;
    step(ex_t0(), 16'd1, "add_t0");
    step(ex_t1(1'b1), 16'd1, "add_t1_first");
    for (int i = 0; i < 4; i++) step(ex_t1(1'b0), 16'd1, "add_t1_wait");
    mem_rdy = 1'b1;
    step(ex_t2(), 16'd1, "add_t2");
    step(ex_t3b(16'h0020), 16'd1, "add_t3");
    step(ex_alu(16'h0004, 12'h001), 16'd1, "add_t4");
    run = 1'b0;
    step(ex_t5(16'h0008), 16'd1, "add_t5");
    step(ex_none(), 16'd2, "add_idle");

    // Memory never ready: FAULT after 15 T1 cycles, sticky until clr
    run = 1'b1; mem_rdy = 1'b0;
    step(ex_t0(), 16'd2, "to_t0");
    step(ex_t1(1'b1), 16'd2, "to_t1_first");
    for (int i = 0; i < 14; i++) step(ex_t1(1'b0), 16'd2, "to_t1_wait");
    step(ex_fault(), 16'd2, "to_fault");
    mem_rdy = 1'b1;
    step(ex_fault(), 16'd2, "to_fault_sticky");
    clr = 1'b1;
    step(ex_none(), 16'd0, "to_clr");
    clr = 1'b0;

    // Illegal opcode 5'h1F
    ir = IR_BAD;
    step(ex_t0(), 16'd0, "bad_t0");
    step(ex_t1(1'b1), 16'd0, "bad_t1");
    step(ex_t2(), 16'd0, "bad_t2");
    step(ex_none(), 16'd0, "bad_t3");
    step(ex_fault(), 16'd0, "bad_fault");
    clr = 1'b1;
    step(ex_none(), 16'd0, "bad_clr");
    clr = 1'b0;

    // HALT opcode: halted without fault, sticky
    ir = IR_HALT;
    step(ex_t0(), 16'd0, "halt_t0");
    step(ex_t1(1'b1), 16'd0, "halt_t1");
    step(ex_t2(), 16'd0, "halt_t2");
    step(ex_none(), 16'd0, "halt_t3");
    step(ex_halt(), 16'd0, "halt_state");
    step(ex_halt(), 16'd0, "halt_sticky");
    clr = 1'b1;
    step(ex_none(), 16'd0, "halt_clr");
    clr = 1'b0;

    // clr during T4 of an ADD aborts to IDLE
    ir = IR_ADD_3_5_2;
    step(ex_t0(), 16'd0, "abort_t0");
    step(ex_t1(1'b1), 16'd0, "abort_t1");
    step(ex_t2(), 16'd0, "abort_t2");
    step(ex_t3b(16'h0020), 16'd0, "abort_t3");
    step(ex_alu(16'h0004, 12'h001), 16'd0, "abort_t4");
    clr = 1'b1;
    step(ex_none(), 16'd0, "abort_clr");
    clr = 1'b0;

    // Three back-to-back NOTs, T5 straight into T0
    ir = IR_NOT_5_2;
    for (int k = 0; k < 3; k++) begin
      step(ex_t0(), 16'(k), "b2b_t0");
      step(ex_t1(1'b1), 16'(k), "b2b_t1");
      step(ex_t2(), 16'(k), "b2b_t2");
      step(ex_alu(16'h0004, 12'h800), 16'(k), "b2b_t3");
      if (k == 2) run = 1'b0;
      step(ex_t5(16'h0020), 16'(k), "b2b_t5");
    end
    step(ex_none(), 16'd3, "b2b_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
